// File: rtl/l1_trigger_pkg.sv
// Purpose: shared types and constants for the L1 trigger collector.
// Latency: n/a (types only).
// Backpressure: n/a.
package l1_trigger_pkg;

    localparam int DROP_COUNT_BITS = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GATHER,
        ST_EMIT,
        ST_HOLDOFF
    } collect_state_t;

    // Counter width able to hold the larger of the gather length and the holdoff length.
    function automatic int cnt_width(input int coinc_window, input int holdoff_clocks);
        int max_v;
        max_v = (coinc_window > holdoff_clocks) ? coinc_window : holdoff_clocks;
        return (max_v < 1) ? 1 : $clog2(max_v + 1);
    endfunction

endpackage

// File: rtl/trig_record_fifo.sv
// Purpose: first-word fall-through record FIFO (storage + pointers only).
// Latency: a push is visible on rdata_o/empty_o the cycle after the write edge.
// Backpressure: caller must not push when full (unless popping) nor pop when empty.
module trig_record_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 16
) (
    input  logic             aclk,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;

    // Storage array; cleared on reset so the head reads zero after reset.
    always_ff @(posedge aclk or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    // Read/write pointers with an extra wrap bit to tell full from empty.
    always_ff @(posedge aclk or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/l1_trigger_collector.sv
// Purpose: mask L1 beam triggers, merge hits in a coincidence window into timestamped records, apply holdoff, queue in a FIFO.
// Latency: record visible COINC_WINDOW+1 clocks after the first hit (FIFO empty); hits during EMIT/HOLDOFF are discarded.
// Backpressure: valid/ready on the FIFO head; a record emitted into a full FIFO is dropped (counted with L1_COLLECT_DROP_COUNT_EN).
module l1_trigger_collector
    import l1_trigger_pkg::*;
#(
    parameter int NBEAMS         = 2,
    parameter int COINC_WINDOW   = 4,
    parameter int HOLDOFF_CLOCKS = 16,
    parameter int TIMESTAMP_BITS = 32,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                       aclk,
    input  logic                       reset_i,
    input  logic [NBEAMS-1:0]          trigger_i,
    input  logic [NBEAMS-1:0]          beam_mask_i,
    output logic                       trig_valid_o,
    input  logic                       trig_ready_i,
    output logic [NBEAMS-1:0]          trig_beams_o,
    output logic [TIMESTAMP_BITS-1:0]  trig_time_o,
    output logic                       busy_o,
    output logic [DROP_COUNT_BITS-1:0] drop_count_o
);

    typedef struct packed {
        logic [NBEAMS-1:0]         beams;
        logic [TIMESTAMP_BITS-1:0] tstamp;
    } trig_record_t;

    localparam int REC_W = $bits(trig_record_t);
    localparam int CNT_W = cnt_width(COINC_WINDOW, HOLDOFF_CLOCKS);
    // Window counter is cleared on the first-hit cycle, so GATHER ends when it reaches COINC_WINDOW-2.
    localparam logic [CNT_W-1:0] GATHER_LAST = CNT_W'((COINC_WINDOW >= 2) ? COINC_WINDOW - 2 : 0);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'((HOLDOFF_CLOCKS >= 1) ? HOLDOFF_CLOCKS - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [TIMESTAMP_BITS-1:0] TS_ONE = TIMESTAMP_BITS'(1);

    collect_state_t            state_q;
    logic [TIMESTAMP_BITS-1:0] ts_q;
    logic [TIMESTAMP_BITS-1:0] t0_q;
    logic [NBEAMS-1:0]         acc_q;
    logic [CNT_W-1:0]          cnt_q;
    logic                      busy_q;

    logic [NBEAMS-1:0] hit;
    logic              pop;
    logic              push;
    logic              fifo_full;
    logic              fifo_empty;
    trig_record_t      wr_rec;
    trig_record_t      rd_rec;

    assign hit  = trigger_i & beam_mask_i;
    assign pop  = trig_valid_o & trig_ready_i;
    // A full FIFO still accepts the record when the head leaves on the same edge.
    assign push = (state_q == ST_EMIT) && (!fifo_full || pop);

    // Free-running timestamp, wraps naturally.
    always_ff @(posedge aclk or posedge reset_i) begin
        if (reset_i) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_ONE;
        end
    end

    // Collector FSM: gather window, one-cycle emit, holdoff; busy is registered alongside.
    always_ff @(posedge aclk or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            t0_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|hit) begin
                        acc_q   <= hit;
                        t0_q    <= ts_q;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= (COINC_WINDOW == 1) ? ST_EMIT : ST_GATHER;
                    end
                end
                ST_GATHER: begin
                    acc_q <= acc_q | hit;
                    cnt_q <= cnt_q + CNT_ONE;
                    if (cnt_q == GATHER_LAST) begin
                        state_q <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    cnt_q <= '0;
                    if (HOLDOFF_CLOCKS == 0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= ST_HOLDOFF;
                    end
                end
                ST_HOLDOFF: begin
                    cnt_q <= cnt_q + CNT_ONE;
                    if (cnt_q == HOLD_LAST) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o = busy_q;

`ifdef L1_COLLECT_DROP_COUNT_EN
    logic                       drop_evt;
    logic [DROP_COUNT_BITS-1:0] drop_cnt_q;
    logic [DROP_COUNT_BITS-1:0] drop_cnt_d;

    assign drop_evt = (state_q == ST_EMIT) && !push;

    // Saturating count of records lost to a full FIFO.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_evt && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    // Drop counter register.
    always_ff @(posedge aclk or posedge reset_i) begin
        if (reset_i) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count_o = drop_cnt_q;
`else
    assign drop_count_o = '0;
`endif

    assign wr_rec.beams  = acc_q;
    assign wr_rec.tstamp = t0_q;

    trig_record_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .aclk    (aclk),
        .reset_i (reset_i),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_rec),
        .rdata_o (rd_rec),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign trig_valid_o = !fifo_empty;
    assign trig_beams_o = rd_rec.beams;
    assign trig_time_o  = rd_rec.tstamp;

endmodule

// File: tb/tb_l1_trigger_collector.sv
// Purpose: randomized and directed stimulus for l1_trigger_collector against a timing-rule reference model.
// Latency: n/a.
// Backpressure: exercises trig_ready_i low (FIFO fill + drops) and random ready.
module tb_l1_trigger_collector;

    localparam int NB    = 2;
    localparam int W     = 4;
    localparam int H     = 16;
    localparam int TSB   = 32;
    localparam int DEPTH = 4;

    logic            aclk;
    logic            reset_i;
    logic [NB-1:0]   trigger_i;
    logic [NB-1:0]   beam_mask_i;
    logic            trig_valid_o;
    logic            trig_ready_i;
    logic [NB-1:0]   trig_beams_o;
    logic [TSB-1:0]  trig_time_o;
    logic            busy_o;
    logic [15:0]     drop_count_o;

    l1_trigger_collector #(
        .NBEAMS         (NB),
        .COINC_WINDOW   (W),
        .HOLDOFF_CLOCKS (H),
        .TIMESTAMP_BITS (TSB),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .aclk         (aclk),
        .reset_i      (reset_i),
        .trigger_i    (trigger_i),
        .beam_mask_i  (beam_mask_i),
        .trig_valid_o (trig_valid_o),
        .trig_ready_i (trig_ready_i),
        .trig_beams_o (trig_beams_o),
        .trig_time_o  (trig_time_o),
        .busy_o       (busy_o),
        .drop_count_o (drop_count_o)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: records described by start time, accumulated beams and the accept-again time.
    typedef struct {
        logic [NB-1:0]  beams;
        logic [TSB-1:0] tstamp;
    } rec_t;

    rec_t          mq[$];
    longint        cyc;
    longint        start_t;
    longint        accept_t;
    bit            have;
    logic [NB-1:0] macc;
    int            drops_m;
    logic [NB-1:0] cur_mask;
    logic          cur_rdy;

    task automatic model_reset();
        mq.delete();
        cyc      = 0;
        start_t  = 0;
        accept_t = 0;
        have     = 0;
        macc     = '0;
        drops_m  = 0;
    endtask

    // One clock: called at a falling edge; checks outputs, drives inputs, advances the model.
    task automatic step(input logic [NB-1:0] trig);
        logic [NB-1:0] hit;
        bit            pop;
        bit            emit;
        bit            busy_exp;
        int            sz;
        rec_t          r;
        check_eq("valid", trig_valid_o, mq.size() != 0);
        if (mq.size() != 0) begin
            check_eq("beams", trig_beams_o, mq[0].beams);
            check_eq("time", trig_time_o, mq[0].tstamp);
        end
        busy_exp = have && (cyc >= start_t + 1) && (cyc <= start_t + W + H);
        check_eq("busy", busy_o, busy_exp);
`ifdef L1_COLLECT_DROP_COUNT_EN
        check_eq("drops", drop_count_o, drops_m);
`else
        check_eq("drops", drop_count_o, 0);
`endif
        trigger_i    = trig;
        beam_mask_i  = cur_mask;
        trig_ready_i = cur_rdy;
        hit  = trig & cur_mask;
        pop  = (mq.size() != 0) && cur_rdy;
        emit = 0;
        if (have && cyc < accept_t) begin
            if (cyc > start_t && cyc <= start_t + W - 1) macc = macc | hit;
            if (cyc == start_t + W) emit = 1;
        end else if (hit != 0) begin
            have     = 1;
            start_t  = cyc;
            macc     = hit;
            accept_t = cyc + W + 1 + H;
        end
        sz = mq.size();
        if (pop) void'(mq.pop_front());
        if (emit) begin
            if (sz < DEPTH || pop) begin
                r.beams  = macc;
                r.tstamp = start_t[TSB-1:0];
                mq.push_back(r);
            end else if (drops_m < 65535) begin
                drops_m++;
            end
        end
        cyc++;
        @(negedge aclk);
    endtask

    task automatic idle_to(input longint t);
        while (cyc < t) step('0);
    endtask

    task automatic do_reset(input int n);
        reset_i   = 1'b1;
        trigger_i = '0;
        model_reset();
        for (int i = 0; i < n; i++) begin
            #1;
            check_eq("rst_valid", trig_valid_o, 0);
            check_eq("rst_beams", trig_beams_o, 0);
            check_eq("rst_time", trig_time_o, 0);
            check_eq("rst_busy", busy_o, 0);
            check_eq("rst_drops", drop_count_o, 0);
            @(negedge aclk);
        end
        reset_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_i      = 1'b1;
        trigger_i    = '0;
        beam_mask_i  = 2'b11;
        trig_ready_i = 1'b1;
        cur_mask     = 2'b11;
        cur_rdy      = 1'b1;
        @(negedge aclk);
        do_reset(3);

        // Single pulse at ts=100.
        idle_to(100); step(2'b01); idle_to(150);

        // Coincident second beam inside the window.
        do_reset(1);
        idle_to(100); step(2'b01); idle_to(103); step(2'b10); idle_to(150);

        // Second beam one cycle past the window: lost to holdoff.
        do_reset(1);
        idle_to(100); step(2'b01); idle_to(104); step(2'b10); idle_to(150);

        // Continuous triggering: records every W+1+H cycles.
        do_reset(1);
        idle_to(100);
        while (cyc < 170) step(2'b11);
        idle_to(200);

        // Masked beam only: no records, never busy.
        do_reset(1);
        cur_mask = 2'b10;
        while (cyc < 120) step((cyc % 7 == 0) ? 2'b01 : 2'b00);
        cur_mask = 2'b11;

        // Backpressure: six separated triggers into a depth-4 FIFO, then drain.
        do_reset(1);
        cur_rdy = 1'b0;
        for (int k = 0; k < 6; k++) begin
            idle_to(10 + 25 * k);
            step(2'b01 << (k % 2));
        end
        idle_to(200);
        cur_rdy = 1'b1;
        idle_to(215);

        // Reset in the middle of a gather window.
        do_reset(1);
        idle_to(20); step(2'b10); step(2'b00);
        do_reset(3);
        idle_to(5); step(2'b01); idle_to(40);

        // Randomized traffic with random ready and occasional mask changes.
        do_reset(1);
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) cur_mask = NB'($urandom_range(0, 3));
            cur_rdy = ($urandom_range(0, 3) != 0);
            if (i % 600 > 450) cur_rdy = 1'b0;
            step(($urandom_range(0, 11) == 0) ? NB'($urandom_range(1, 3)) : NB'(0));
        end
        cur_rdy = 1'b1;
        for (int i = 0; i < 40; i++) step('0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
